// File: rtl/conv_tile_sched_if.sv
// conv_tile_sched_if: scheduler control bus (x load handshake, memory addresses/enables, y drain handshake)
interface conv_tile_sched_if #(
  parameter int SIZE_X = 96,
  parameter int SIZE_F = 65,
  parameter int P = 4
);
  localparam int CONV_POINTS = SIZE_X - SIZE_F + 1;
  localparam int TILES = (CONV_POINTS + P - 1) / P;
  localparam int XW = $clog2(SIZE_X);
  localparam int FW = $clog2(SIZE_F);
  localparam int YW = TILES > 1 ? $clog2(TILES) : 1;
  localparam int LW = P > 1 ? $clog2(P) : 1;
  logic x_valid, x_ready, x_wr_en;
  logic [XW-1:0] x_addr;
  logic [FW-1:0] f_addr;
  logic mac_clear, mac_en, y_wr_en;
  logic [YW-1:0] y_addr;
  logic [LW-1:0] y_sel;
  logic y_valid, y_ready, frame_done;
  modport master (
    input x_valid, y_ready,
    output x_ready, x_wr_en, x_addr, f_addr, mac_clear, mac_en, y_wr_en, y_addr, y_sel, y_valid, frame_done
  );
  modport slave (
    output x_valid, y_ready,
    input x_ready, x_wr_en, x_addr, f_addr, mac_clear, mac_en, y_wr_en, y_addr, y_sel, y_valid, frame_done
  );
endinterface

// File: rtl/conv_tile_sched.sv
// conv_tile_sched: load/compute/drain sequencer for the P-lane convolution datapath
module conv_tile_sched #(
  parameter int SIZE_X = 96,
  parameter int SIZE_F = 65,
  parameter int P = 4,
  parameter int MAC_LAT = 3
) (
  input logic clk,
  input logic reset,
  conv_tile_sched_if.master bus
);
  localparam int CONV_POINTS = SIZE_X - SIZE_F + 1;
  localparam int TILES = (CONV_POINTS + P - 1) / P;
  localparam int XW = $clog2(SIZE_X);
  localparam int FW = $clog2(SIZE_F);
  localparam int YW = TILES > 1 ? $clog2(TILES) : 1;
  localparam int LW = P > 1 ? $clog2(P) : 1;
  localparam int CW = MAC_LAT > 0 ? $clog2(MAC_LAT + 1) : 1;
  localparam int LAST_LANE = (CONV_POINTS - 1) % P;
  typedef enum logic [2:0] {LOAD, CLEAR, ACC, FLUSH, WRITE, DRAIN} state_t;
  state_t state, state_n;
  logic [XW-1:0] k;
  logic [FW-1:0] j;
  logic [CW-1:0] c;
  logic [YW-1:0] t;
  logic [LW-1:0] lane;
  logic x_rdy, mac_q, y_vld, x_hs, y_hs, last_hs;
  always_comb begin
    x_hs = bus.x_valid & x_rdy;
    y_hs = y_vld & bus.y_ready;
    last_hs = y_hs && t == YW'(TILES - 1) && lane == LW'(LAST_LANE);
    state_n = state;
    case (state)
      LOAD: state_n = x_hs && k == XW'(SIZE_X - 1) ? CLEAR : LOAD;
      CLEAR: state_n = ACC;
      ACC: state_n = j == FW'(SIZE_F - 1) ? FLUSH : ACC;
      FLUSH: state_n = c == CW'(MAC_LAT) ? WRITE : FLUSH;
      WRITE: state_n = t == YW'(TILES - 1) ? DRAIN : CLEAR;
      DRAIN: state_n = last_hs ? LOAD : DRAIN;
      default: state_n = LOAD;
    endcase
    bus.x_ready = x_rdy;
    bus.x_wr_en = x_hs;
    bus.x_addr = state == LOAD ? k : state == ACC ? XW'(int'(t) * P + int'(j)) : '0;
    bus.f_addr = state == ACC ? j : '0;
    bus.mac_clear = state == CLEAR;
    bus.mac_en = mac_q;
    bus.y_wr_en = state == WRITE;
    bus.y_addr = state == WRITE || state == DRAIN ? t : '0;
    bus.y_sel = state == DRAIN ? lane : '0;
    bus.y_valid = y_vld;
    bus.frame_done = last_hs;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= LOAD;
      k <= '0;
      j <= '0;
      c <= '0;
      t <= '0;
      lane <= '0;
      x_rdy <= 1'b0;
      mac_q <= 1'b0;
      y_vld <= 1'b0;
    end else begin
      state <= state_n;
      x_rdy <= state_n == LOAD;
      mac_q <= state == ACC;
      y_vld <= state == DRAIN && !y_hs;
      k <= state_n == LOAD ? k + XW'(x_hs) : '0;
      j <= state == ACC && state_n == ACC ? j + FW'(1) : '0;
      c <= state == FLUSH && state_n == FLUSH ? c + CW'(1) : '0;
      t <= state == WRITE ? (state_n == DRAIN ? '0 : t + YW'(1)) :
           state == DRAIN ? (last_hs ? '0 : t + YW'(y_hs && lane == LW'(P - 1))) : t;
      lane <= state == DRAIN && y_hs && lane != LW'(P - 1) ? lane + LW'(1) :
              state == DRAIN && !y_hs ? lane : '0;
    end
endmodule

// File: tb/tb_conv_tile_sched.sv
// tb_conv_tile_sched: directed self-checking bench for conv_tile_sched (default and small parameter sets)
module tb_conv_tile_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cmp = 0;
  int errs = 0;
  int n, stall, wr;
  logic yr;
  always #5 clk = ~clk;
  conv_tile_sched_if #(.SIZE_X(96), .SIZE_F(65), .P(4)) bus ();
  conv_tile_sched_if #(.SIZE_X(10), .SIZE_F(4), .P(3)) sb ();
  conv_tile_sched #(.SIZE_X(96), .SIZE_F(65), .P(4), .MAC_LAT(3)) dut (.clk(clk), .reset(rst_n), .bus(bus));
  conv_tile_sched #(.SIZE_X(10), .SIZE_F(4), .P(3), .MAC_LAT(3)) dut_s (.clk(clk), .reset(rst_n), .bus(sb));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic xv, input logic yrd);
    @(negedge clk);
    bus.x_valid = xv;
    bus.y_ready = yrd;
    #1;
  endtask
  task automatic cyc_s(input logic xv, input logic yrd);
    @(negedge clk);
    sb.x_valid = xv;
    sb.y_ready = yrd;
    #1;
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_x_ready"}, bus.x_ready, 0);
    check({tag, "_x_wr_en"}, bus.x_wr_en, 0);
    check({tag, "_x_addr"}, bus.x_addr, 0);
    check({tag, "_f_addr"}, bus.f_addr, 0);
    check({tag, "_mac_clear"}, bus.mac_clear, 0);
    check({tag, "_mac_en"}, bus.mac_en, 0);
    check({tag, "_y_wr_en"}, bus.y_wr_en, 0);
    check({tag, "_y_addr"}, bus.y_addr, 0);
    check({tag, "_y_sel"}, bus.y_sel, 0);
    check({tag, "_y_valid"}, bus.y_valid, 0);
    check({tag, "_frame_done"}, bus.frame_done, 0);
  endtask
  task automatic load_frame();
    for (int i = 0; i < 96; i++) begin
      cyc(1, 0);
      check("load_wr_en", bus.x_wr_en, 1);
      check("load_x_addr", bus.x_addr, i);
    end
  endtask
  // Each tile: CLEAR, 65 ACC, 4 FLUSH, WRITE = 71 cycles; x_valid/y_ready held high to prove they are ignored.
  task automatic compute(input int cycles);
    for (int g = 0; g < cycles; g++) begin
      int t, c;
      t = g / 71;
      c = g % 71;
      cyc(1, 1);
      check("mac_clear", bus.mac_clear, c == 0);
      check("mac_en", bus.mac_en, c >= 2 && c <= 66);
      check("y_wr_en", bus.y_wr_en, c == 70);
      check("c_x_ready", bus.x_ready, 0);
      check("c_x_wr_en", bus.x_wr_en, 0);
      check("c_y_valid", bus.y_valid, 0);
      if (c >= 1 && c <= 65) begin
        check("acc_f_addr", bus.f_addr, c - 1);
        check("acc_x_addr", bus.x_addr, t * 4 + c - 1);
      end
      if (c == 70) check("wr_y_addr", bus.y_addr, t);
    end
  endtask
  task automatic drain_ordered();
    for (int i = 0; i < 32; i++) begin
      cyc(0, 1);
      check("d_idle_valid", bus.y_valid, 0);
      check("d_idle_addr", bus.y_addr, i / 4);
      check("d_idle_sel", bus.y_sel, i % 4);
      check("d_idle_done", bus.frame_done, 0);
      cyc(0, 1);
      check("d_valid", bus.y_valid, 1);
      check("d_addr", bus.y_addr, i / 4);
      check("d_sel", bus.y_sel, i % 4);
      check("d_done", bus.frame_done, i == 31);
    end
    cyc(0, 0);
    check("d_after_x_ready", bus.x_ready, 1);
    check("d_after_y_valid", bus.y_valid, 0);
    check("d_after_done", bus.frame_done, 0);
  endtask
  initial begin
    bus.x_valid = 1'b0;
    bus.y_ready = 1'b0;
    sb.x_valid = 1'b0;
    sb.y_ready = 1'b0;
    cyc(1, 1);
    check_zero("rst");
    cyc(1, 1);
    check_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    bus.x_valid = 1'b0;
    bus.y_ready = 1'b0;
    #1;
    check("rel_x_ready", bus.x_ready, 0);
    cyc(0, 0);
    check("post_rel_x_ready", bus.x_ready, 1);
    load_frame();
    compute(568);
    drain_ordered();
    load_frame();
    n = 0;
    stall = 0;
    for (int g = 0; g < 3000 && n < 32; g++) begin
      yr = (n == 5 && stall < 20) ? 1'b0 : 1'($urandom_range(0, 1));
      cyc(0, yr);
      if (bus.y_valid) begin
        check("r_addr", bus.y_addr, n / 4);
        check("r_sel", bus.y_sel, n % 4);
        if (n == 5 && !yr) stall++;
        if (yr) begin
          check("r_done", bus.frame_done, n == 31);
          n++;
        end
      end
    end
    check("r_count", n, 32);
    check("r_stall", stall >= 20, 1);
    load_frame();
    compute(224);
    #2 rst_n = 1'b0;
    #1;
    check_zero("abort");
    cyc(0, 0);
    check_zero("abort_hold");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_rel_x_ready", bus.x_ready, 0);
    cyc(0, 0);
    check("abort_post_x_ready", bus.x_ready, 1);
    load_frame();
    compute(568);
    drain_ordered();
    for (int i = 0; i < 10; i++) begin
      cyc_s(1, 0);
      check("s_wr_en", sb.x_wr_en, 1);
      check("s_x_addr", sb.x_addr, i);
    end
    n = 0;
    wr = 0;
    for (int g = 0; g < 300 && n < 7; g++) begin
      cyc_s(0, 1);
      if (sb.y_wr_en) wr++;
      if (sb.y_valid) begin
        check("s_y_addr", sb.y_addr, n / 3);
        check("s_y_sel", sb.y_sel, n % 3);
        check("s_done", sb.frame_done, n == 6);
        n++;
      end
    end
    check("s_count", n, 7);
    check("s_y_wr_cnt", wr, 3);
    cyc_s(0, 0);
    check("s_x_ready", sb.x_ready, 1);
    check("s_y_valid_after", sb.y_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
